led_walker_bus: RTL and testbench

Bus-controlled LED walker with configurable length, step rate, sweep/bounce mode and repeat count. It sits behind a Wishbone-classic slave port between the bus interconnect (or a button-to-strobe front end) and the board LED pins. It stalls only start requests that arrive while a walk is in progress, and it exposes status and a completed-walk counter for readback.

---
 rtl/led_walker_bus_if.sv | 13 +
 rtl/led_walker_bus.sv | 110 +++++++++++
 tb/tb_led_walker_bus.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_walker_bus_if.sv
// led_walker_bus_if: Wishbone-classic request/response bundle for the LED walker
interface led_walker_bus_if;
   logic        i_cyc;
   logic        i_stb;
   logic        i_we;
   logic [1:0]  i_addr;
   logic [31:0] i_data;
   logic        o_stall;
   logic        o_ack;
   logic [31:0] o_data;
   modport master (output i_cyc, i_stb, i_we, i_addr, i_data, input o_stall, o_ack, o_data);
   modport slave  (input i_cyc, i_stb, i_we, i_addr, i_data, output o_stall, o_ack, o_data);
endinterface

// File: rtl/led_walker_bus.sv
// led_walker_bus: bus-controlled one-hot LED walker with sweep/bounce passes and done counter
module led_walker_bus #(
   parameter int NLEDS       = 6,
   parameter int CLK_DIV_W   = 24,
   parameter int DEFAULT_DIV = 1
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   led_walker_bus_if.slave  bus,
   output logic [NLEDS-1:0] o_led,
   output logic             o_busy
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [7:0] LAST = 8'(NLEDS - 1);
   state_t               state_q, state_d;
   logic [7:0]           pos_q, pos_d;
   logic                 up_q, up_d;
   logic                 mode_q, mode_d;
   logic [3:0]           passes_q, passes_d;
   logic [CLK_DIV_W-1:0] div_q, div_d, cnt_q, cnt_d, period;
   logic [15:0]          done_q, done_d;
   logic                 ack_q;
   logic [31:0]          rdata_q, rdata_d, status;
   logic                 req, stall, acc, wr_ctrl, start, abort, step, last_pos, finish;
   assign req      = bus.i_cyc & bus.i_stb;
   assign stall    = req & bus.i_we & (bus.i_addr == 2'd0) & bus.i_data[0] & !bus.i_data[1] & (state_q == RUN);
   assign acc      = req & !stall;
   assign wr_ctrl  = acc & bus.i_we & (bus.i_addr == 2'd0);
   assign start    = wr_ctrl & bus.i_data[0] & (state_q == IDLE);
   assign abort    = wr_ctrl & bus.i_data[1] & (state_q == RUN);
   assign period   = (div_d == '0) ? CLK_DIV_W'(1) : div_d;
   assign step     = (state_q == RUN) & (cnt_q == '0);
   assign last_pos = mode_q ? (!up_q && pos_q == 8'd0) : (pos_q == LAST);
   assign finish   = step & last_pos & (passes_q == 4'd1);
   assign status   = {12'b0, passes_q, pos_q, 6'b0, mode_q, state_q == RUN};
   assign bus.o_stall = stall;
   assign bus.o_ack   = ack_q;
   assign bus.o_data  = rdata_q;
   assign o_busy      = state_q == RUN;
   assign o_led       = (state_q == RUN) ? NLEDS'(1) << pos_q : '0;
   // next-state: bus register writes, walk stepping and pass bookkeeping; abort outranks completion
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_q;
      up_d     = up_q;
      mode_d   = mode_q;
      passes_d = passes_q;
      cnt_d    = cnt_q;
      div_d    = (acc & bus.i_we & bus.i_addr == 2'd1) ? bus.i_data[CLK_DIV_W-1:0] : div_q;
      done_d   = (acc & bus.i_we & bus.i_addr == 2'd3) ? 16'd0 : done_q + 16'(finish & !abort);
      rdata_d  = !(acc & !bus.i_we) ? 32'd0 :
                 bus.i_addr == 2'd1 ? 32'(div_q) :
                 bus.i_addr == 2'd2 ? status :
                 bus.i_addr == 2'd3 ? {16'd0, done_q} : 32'd0;
      if (start) begin
         state_d  = RUN;
         pos_d    = 8'd0;
         up_d     = 1'b1;
         mode_d   = bus.i_data[2];
         passes_d = (bus.i_data[11:8] == 4'd0) ? 4'd1 : bus.i_data[11:8];
         cnt_d    = period - CLK_DIV_W'(1);
      end else if (abort | finish) begin
         state_d  = IDLE;
         pos_d    = 8'd0;
         up_d     = 1'b1;
         passes_d = 4'd0;
         cnt_d    = '0;
      end else if (state_q == RUN) begin
         cnt_d = step ? period - CLK_DIV_W'(1) : cnt_q - CLK_DIV_W'(1);
         if (step) begin
            if (last_pos) begin
               pos_d    = 8'd0;
               up_d     = 1'b1;
               passes_d = passes_q - 4'd1;
            end else if (mode_q && up_q && pos_q == LAST) begin
               pos_d = LAST - 8'd1;
               up_d  = 1'b0;
            end else begin
               pos_d = up_q ? pos_q + 8'd1 : pos_q - 8'd1;
            end
         end
      end
   end
   // state and bus response registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= IDLE;
         pos_q    <= 8'd0;
         up_q     <= 1'b1;
         mode_q   <= 1'b0;
         passes_q <= 4'd0;
         cnt_q    <= '0;
         div_q    <= CLK_DIV_W'(DEFAULT_DIV);
         done_q   <= 16'd0;
         ack_q    <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         pos_q    <= pos_d;
         up_q     <= up_d;
         mode_q   <= mode_d;
         passes_q <= passes_d;
         cnt_q    <= cnt_d;
         div_q    <= div_d;
         done_q   <= done_d;
         ack_q    <= acc;
         rdata_q  <= rdata_d;
      end
   end
endmodule

// File: tb/tb_led_walker_bus.sv
// tb_led_walker_bus: directed scenarios plus randomized bus traffic against a queue-based walk model
module tb_led_walker_bus;
   localparam int N = 6;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [N-1:0] led;
   logic busy;
   led_walker_bus_if bus();
   led_walker_bus #(.NLEDS(N), .CLK_DIV_W(24), .DEFAULT_DIV(1)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .bus(bus), .o_led(led), .o_busy(busy));
   always #5 clk = ~clk;
   int tests = 0;
   int fails = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // model: the walk is the list of positions still to show; front is the lit LED
   int          q[$];
   bit          m_busy = 0, m_mode = 0, m_ack = 0;
   int          m_left = 0, m_plen = N;
   logic [23:0] m_div = 24'd1, m_nd;
   logic [15:0] m_done = 16'd0;
   logic [31:0] m_rdata = 32'd0, m_rmask = 32'hFFFF_FFFF;
   bit          m_acc, m_ctl, m_fin, m_ab, m_old;
   int          m_np;
   function automatic int eff(input logic [23:0] d);
      return (d == 24'd0) ? 1 : int'(d);
   endfunction
   function automatic logic m_stall();
      return bus.i_cyc & bus.i_stb & bus.i_we & (bus.i_addr == 2'd0) & bus.i_data[0] & !bus.i_data[1] & m_busy;
   endfunction
   function automatic logic [31:0] m_status();
      int p;
      p = m_busy ? (q.size() + m_plen - 1) / m_plen : 0;
      return {12'd0, 4'(p), m_busy ? 8'(q[0]) : 8'd0, 6'd0, m_mode, m_busy};
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_busy = 0; m_mode = 0; m_ack = 0; m_left = 0; m_plen = N;
         m_div = 24'd1; m_done = 16'd0; m_rdata = 32'd0; m_rmask = 32'hFFFF_FFFF;
      end else begin
         m_acc = bus.i_cyc & bus.i_stb & !m_stall();
         m_old = m_busy;
         m_ack = m_acc;
         m_rdata = 32'd0;
         m_rmask = 32'hFFFF_FFFF;
         if (m_acc && !bus.i_we) begin
            if (bus.i_addr == 2'd1) m_rdata = {8'd0, m_div};
            if (bus.i_addr == 2'd2) begin
               m_rdata = m_status();
               if (!m_busy) m_rmask = 32'h3;
            end
            if (bus.i_addr == 2'd3) m_rdata = {16'd0, m_done};
         end
         m_ctl = m_acc && bus.i_we && bus.i_addr == 2'd0;
         m_nd = (m_acc && bus.i_we && bus.i_addr == 2'd1) ? bus.i_data[23:0] : m_div;
         m_ab = m_ctl && bus.i_data[1] && m_old;
         m_fin = 0;
         if (m_old) begin
            m_left--;
            if (m_left == 0) begin
               void'(q.pop_front());
               if (q.size() == 0) m_fin = 1;
               else m_left = eff(m_nd);
            end
         end
         if (m_ab || m_fin) begin
            m_busy = 0;
            q.delete();
         end else if (m_ctl && bus.i_data[0] && !m_old) begin
            m_busy = 1;
            m_mode = bus.i_data[2];
            m_np = (bus.i_data[11:8] == 4'd0) ? 1 : int'(bus.i_data[11:8]);
            m_plen = m_mode ? 2 * N - 1 : N;
            for (int p = 0; p < m_np; p++) begin
               for (int i = 0; i < N; i++) q.push_back(i);
               if (m_mode) for (int i = N - 2; i >= 0; i--) q.push_back(i);
            end
            m_left = eff(m_nd);
         end
         m_done = (m_acc && bus.i_we && bus.i_addr == 2'd3) ? 16'd0 : m_done + 16'(m_fin && !m_ab);
         m_div = m_nd;
      end
   end
   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (rst_n) begin
         check("led", 32'(led), m_busy ? (32'd1 << q[0]) : 32'd0);
         check("busy", 32'(busy), 32'(m_busy));
         check("ack", 32'(bus.o_ack), 32'(m_ack));
         check("rdata", bus.o_data & m_rmask, m_rdata & m_rmask);
         check("stall", 32'(bus.o_stall), 32'(m_stall()));
      end
   end
   int run_len = 0, last_run = 0;
   always @(negedge clk) begin
      if (!rst_n) run_len = 0;
      else if (busy) run_len++;
      else if (run_len != 0) begin
         last_run = run_len;
         run_len = 0;
      end
   end
   task automatic xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output int stalls);
      stalls = 0;
      @(posedge clk);
      #1;
      bus.i_cyc = 1'b1; bus.i_stb = 1'b1; bus.i_we = we; bus.i_addr = a; bus.i_data = d;
      @(negedge clk);
      while (bus.o_stall === 1'b1 && stalls < 2000) begin
         stalls++;
         @(negedge clk);
      end
      if (stalls >= 2000) begin
         tests++; fails++;
         $display("FAIL stall_timeout: stall still high after %0d cycles", stalls);
      end
      @(posedge clk);
      #1;
      bus.i_stb = 1'b0; bus.i_we = 1'b0;
      @(negedge clk);
      rd = bus.o_data;
   endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      logic [31:0] rd;
      int st;
      xfer(1'b1, a, d, rd, st);
   endtask
   task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
      logic [31:0] rd;
      int st;
      xfer(1'b0, a, 32'd0, rd, st);
      check(name, rd, exp);
   endtask
   task automatic wait_idle();
      int n = 0;
      while (busy === 1'b1 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         tests++; fails++;
         $display("FAIL walk_timeout: busy still high after %0d cycles", n);
      end
   endtask
   initial begin
      logic [31:0] rd, d;
      logic [1:0] a;
      logic we;
      int st;
      bus.i_cyc = 0; bus.i_stb = 0; bus.i_we = 0; bus.i_addr = 0; bus.i_data = 0;
      #3;
      check("rst_led", 32'(led), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ack", 32'(bus.o_ack), 32'd0);
      check("rst_data", bus.o_data, 32'd0);
      #20 rst_n = 1'b1;
      rd_chk("rst_div", 2'd1, 32'd1);
      rd_chk("rst_done", 2'd3, 32'd0);
      rd_chk("rst_status", 2'd2, 32'd0);
      rd_chk("ctrl_read", 2'd0, 32'd0);
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h101);
      check("sweep_led0", 32'(led), 32'h01);
      repeat (3) @(negedge clk);
      check("sweep_led1", 32'(led), 32'h02);
      wait_idle();
      rd_chk("sweep_done", 2'd3, 32'd1);
      check("sweep_len", 32'(last_run), 32'd18);
      wr(2'd1, 32'd2);
      wr(2'd0, 32'h205);
      rd_chk("bounce_status_a", 2'd2, 32'h0002_0003);
      repeat (24) @(posedge clk);
      rd_chk("bounce_status_b", 2'd2, 32'h0001_0203);
      wait_idle();
      rd_chk("bounce_done", 2'd3, 32'd2);
      check("bounce_len", 32'(last_run), 32'd44);
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h101);
      xfer(1'b1, 2'd0, 32'h101, rd, st);
      check("stall_cycles", 32'(st), 32'd5);
      check("stall_ack", 32'(bus.o_ack), 32'd1);
      check("restart_busy", 32'(busy), 32'd1);
      check("restart_led", 32'(led), 32'h01);
      wait_idle();
      rd_chk("stall_done", 2'd3, 32'd4);
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h101);
      repeat (4) @(posedge clk);
      xfer(1'b1, 2'd0, 32'h3, rd, st);
      check("abort_stall", 32'(st), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_led", 32'(led), 32'd0);
      rd_chk("abort_done", 2'd3, 32'd4);
      wr(2'd1, 32'd1);
      wr(2'd0, 32'h101);
      repeat (4) @(posedge clk);
      wr(2'd3, 32'h1234);
      check("collide_idle", 32'(busy), 32'd0);
      rd_chk("collide_done", 2'd3, 32'd0);
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h105);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("areset_led", 32'(led), 32'd0);
      check("areset_busy", 32'(busy), 32'd0);
      check("areset_ack", 32'(bus.o_ack), 32'd0);
      check("areset_data", bus.o_data, 32'd0);
      #3 rst_n = 1'b1;
      rd_chk("areset_div", 2'd1, 32'd1);
      rd_chk("areset_done", 2'd3, 32'd0);
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h101);
      wait_idle();
      rd_chk("post_reset_done", 2'd3, 32'd1);
      check("post_reset_len", 32'(last_run), 32'd18);
      for (int k = 0; k < 300; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #1;
            bus.i_cyc = 1'($urandom_range(0, 1));
            bus.i_stb = !bus.i_cyc && ($urandom_range(0, 1) == 1);
            bus.i_we = 1'($urandom_range(0, 1));
            bus.i_addr = 2'($urandom_range(0, 3));
            bus.i_data = $urandom;
         end
         a = 2'($urandom_range(0, 3));
         we = 1'($urandom_range(0, 1));
         d = $urandom;
         if (a == 2'd0) begin
            d[11:8] = 4'($urandom_range(0, 3));
            d[0] = $urandom_range(0, 3) != 0;
            d[1] = $urandom_range(0, 7) == 0;
         end
         if (a == 2'd1) d = (d & 32'hFF00_0000) | 32'($urandom_range(0, 4));
         xfer(we, a, d, rd, st);
      end
      wait_idle();
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
